// File: rtl/core161c_memory_pkg.sv
// Shared types and sizes for the core161c 16K x 36 core memory module.
package core161c_memory_pkg;
  localparam int WORD_W    = 36;
  localparam int ADDR_W    = 14;
  localparam int MEM_DEPTH = 16384;
  localparam int NPORTS    = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WAIT_WR = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Bus bits 22:35 form the word index; bit 21 belongs to the module select.
  function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W:0] ma);
    return ma[ADDR_W-1:0];
  endfunction
endpackage

// File: rtl/core161c_port_arb.sv
// Qualifies membus requests on the four processor ports and picks one, p0 highest.
module core161c_port_arb
  import core161c_memory_pkg::*;
#(
  parameter logic [3:0] MEMSEL_P0 = 4'b0000,
  parameter logic [3:0] MEMSEL_P1 = 4'b0000,
  parameter logic [3:0] MEMSEL_P2 = 4'b0000,
  parameter logic [3:0] MEMSEL_P3 = 4'b0000
) (
  input  logic [NPORTS-1:0]      rd_rq,
  input  logic [NPORTS-1:0]      wr_rq,
  input  logic [NPORTS-1:0]      rq_cyc,
  input  logic [NPORTS-1:0]      fmc_select,
  input  logic [NPORTS-1:0][3:0] sel,
  output logic [1:0]             sel_idx,
  output logic                   valid
);
  logic [NPORTS-1:0]      qual_s;
  logic [NPORTS-1:0][3:0] memsel_s;

  // Per-port qualification against this module's select value
  always_comb begin
    memsel_s = {MEMSEL_P3, MEMSEL_P2, MEMSEL_P1, MEMSEL_P0};
    qual_s   = 4'b0000;
    for (int i = 0; i < NPORTS; i++) begin
      qual_s[i] = rq_cyc[i] && (sel[i] == memsel_s[i]) && !fmc_select[i]
                  && (rd_rq[i] || wr_rq[i]);
    end
  end

  // Fixed priority encoder
  always_comb begin
    valid = |qual_s;
    if (qual_s[0]) begin
      sel_idx = 2'd0;
    end else if (qual_s[1]) begin
      sel_idx = 2'd1;
    end else if (qual_s[2]) begin
      sel_idx = 2'd2;
    end else if (qual_s[3]) begin
      sel_idx = 2'd3;
    end else begin
      sel_idx = 2'd0;
    end
  end
endmodule

// File: rtl/core161c_memory.sv
// 16K x 36 core memory on the PDP-10 membus: four ports, destructive read with
// restore, read-modify-write and single-step support.
module core161c_memory
  import core161c_memory_pkg::*;
#(
  parameter logic [3:0] memsel_p0 = 4'b0000,
  parameter logic [3:0] memsel_p1 = 4'b0000,
  parameter logic [3:0] memsel_p2 = 4'b0000,
  parameter logic [3:0] memsel_p3 = 4'b0000,
  parameter int         READ_DLY  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        power,
  input  logic        sw_single_step,
  input  logic        sw_restart,
  input  logic        membus_rd_rq_p0,
  input  logic        membus_wr_rq_p0,
  input  logic        membus_rq_cyc_p0,
  input  logic [3:0]  membus_sel_p0,
  input  logic        membus_fmc_select_p0,
  input  logic [14:0] membus_ma_p0,
  input  logic        membus_wr_rs_p0,
  input  logic [35:0] membus_mb_in_p0,
  output logic        membus_addr_ack_p0,
  output logic        membus_rd_rs_p0,
  output logic [35:0] membus_mb_out_p0,
  input  logic        membus_rd_rq_p1,
  input  logic        membus_wr_rq_p1,
  input  logic        membus_rq_cyc_p1,
  input  logic [3:0]  membus_sel_p1,
  input  logic        membus_fmc_select_p1,
  input  logic [14:0] membus_ma_p1,
  input  logic        membus_wr_rs_p1,
  input  logic [35:0] membus_mb_in_p1,
  output logic        membus_addr_ack_p1,
  output logic        membus_rd_rs_p1,
  output logic [35:0] membus_mb_out_p1,
  input  logic        membus_rd_rq_p2,
  input  logic        membus_wr_rq_p2,
  input  logic        membus_rq_cyc_p2,
  input  logic [3:0]  membus_sel_p2,
  input  logic        membus_fmc_select_p2,
  input  logic [14:0] membus_ma_p2,
  input  logic        membus_wr_rs_p2,
  input  logic [35:0] membus_mb_in_p2,
  output logic        membus_addr_ack_p2,
  output logic        membus_rd_rs_p2,
  output logic [35:0] membus_mb_out_p2,
  input  logic        membus_rd_rq_p3,
  input  logic        membus_wr_rq_p3,
  input  logic        membus_rq_cyc_p3,
  input  logic [3:0]  membus_sel_p3,
  input  logic        membus_fmc_select_p3,
  input  logic [14:0] membus_ma_p3,
  input  logic        membus_wr_rs_p3,
  input  logic [35:0] membus_mb_in_p3,
  output logic        membus_addr_ack_p3,
  output logic        membus_rd_rs_p3,
  output logic [35:0] membus_mb_out_p3
);
  localparam logic [2:0] CNT_LAST = 3'(READ_DLY - 1);

  logic [WORD_W-1:0] core [0:MEM_DEPTH-1];

  logic [NPORTS-1:0]              rd_rq_s, wr_rq_s, rq_cyc_s, fmc_s, wr_rs_s;
  logic [NPORTS-1:0][3:0]         sel_s;
  logic [NPORTS-1:0][ADDR_W:0]    ma_s;
  logic [NPORTS-1:0][WORD_W-1:0]  mb_in_s;
  logic [1:0]                     arb_idx_s;
  logic                           arb_valid_s;
  logic                           unused_ma_hi_s;

  state_e                         state_q, state_d;
  logic [1:0]                     port_q, port_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic                           rd_q, rd_d, wr_q, wr_d, step_ok_q, step_ok_d;
  logic [2:0]                     cnt_q, cnt_d;
  logic [WORD_W-1:0]              mb_q, mb_d;
  logic [NPORTS-1:0]              addr_ack_q, addr_ack_d, rd_rs_q, rd_rs_d;
  logic [NPORTS-1:0][WORD_W-1:0]  mb_out_q, mb_out_d;
  logic                           core_we_s;
  logic [WORD_W-1:0]              core_wdata_s, core_rdata_s;

  assign rd_rq_s  = {membus_rd_rq_p3, membus_rd_rq_p2, membus_rd_rq_p1, membus_rd_rq_p0};
  assign wr_rq_s  = {membus_wr_rq_p3, membus_wr_rq_p2, membus_wr_rq_p1, membus_wr_rq_p0};
  assign rq_cyc_s = {membus_rq_cyc_p3, membus_rq_cyc_p2, membus_rq_cyc_p1, membus_rq_cyc_p0};
  assign fmc_s    = {membus_fmc_select_p3, membus_fmc_select_p2,
                     membus_fmc_select_p1, membus_fmc_select_p0};
  assign wr_rs_s  = {membus_wr_rs_p3, membus_wr_rs_p2, membus_wr_rs_p1, membus_wr_rs_p0};
  assign sel_s    = {membus_sel_p3, membus_sel_p2, membus_sel_p1, membus_sel_p0};
  assign ma_s     = {membus_ma_p3, membus_ma_p2, membus_ma_p1, membus_ma_p0};
  assign mb_in_s  = {membus_mb_in_p3, membus_mb_in_p2, membus_mb_in_p1, membus_mb_in_p0};
  assign unused_ma_hi_s = ^{ma_s[3][ADDR_W], ma_s[2][ADDR_W], ma_s[1][ADDR_W], ma_s[0][ADDR_W]};

  core161c_port_arb #(
    .MEMSEL_P0(memsel_p0), .MEMSEL_P1(memsel_p1),
    .MEMSEL_P2(memsel_p2), .MEMSEL_P3(memsel_p3)
  ) u_arb (
    .rd_rq(rd_rq_s), .wr_rq(wr_rq_s), .rq_cyc(rq_cyc_s), .fmc_select(fmc_s),
    .sel(sel_s), .sel_idx(arb_idx_s), .valid(arb_valid_s)
  );

  assign core_rdata_s = core[addr_q];

  // Memory cycle sequencing; power loss behaves like a synchronous abort
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    mb_d         = mb_q;
    step_ok_d    = step_ok_q;
    addr_ack_d   = 4'b0000;
    rd_rs_d      = 4'b0000;
    mb_out_d     = '0;
    core_we_s    = 1'b0;
    core_wdata_s = 36'd0;
    if (!power) begin
      state_d   = ST_IDLE;
      mb_d      = 36'd0;
      cnt_d     = 3'd0;
      step_ok_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid_s) begin
            port_d              = arb_idx_s;
            addr_d              = word_index(ma_s[arb_idx_s]);
            rd_d                = rd_rq_s[arb_idx_s];
            wr_d                = wr_rq_s[arb_idx_s];
            cnt_d               = 3'd0;
            addr_ack_d[arb_idx_s] = 1'b1;
            state_d             = ST_READ;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_READ: begin
          if (cnt_q == CNT_LAST) begin
            // Destructive read: the word lives only in mb until restored.
            core_we_s    = 1'b1;
            core_wdata_s = 36'd0;
            mb_d         = rd_q ? core_rdata_s : 36'd0;
            if (rd_q) begin
              rd_rs_d[port_q]  = 1'b1;
              mb_out_d[port_q] = core_rdata_s;
            end else begin
              rd_rs_d = 4'b0000;
            end
            state_d = wr_q ? ST_WAIT_WR : ST_WRITE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_WAIT_WR: begin
          if (wr_rs_s[port_q]) begin
            mb_d    = mb_in_s[port_q];
            state_d = ST_WRITE;
          end else if (!rq_cyc_s[port_q]) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_WAIT_WR;
          end
        end
        ST_WRITE: begin
          core_we_s    = 1'b1;
          core_wdata_s = mb_q;
          step_ok_d    = 1'b0;
          state_d      = ST_DONE;
        end
        ST_DONE: begin
          if (sw_single_step && !step_ok_q) begin
            step_ok_d = sw_restart;
          end else if (!rq_cyc_s[port_q]) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      port_q     <= 2'd0;
      addr_q     <= 14'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= 3'd0;
      mb_q       <= 36'd0;
      step_ok_q  <= 1'b0;
      addr_ack_q <= 4'b0000;
      rd_rs_q    <= 4'b0000;
      mb_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      mb_q       <= mb_d;
      step_ok_q  <= step_ok_d;
      addr_ack_q <= addr_ack_d;
      rd_rs_q    <= rd_rs_d;
      mb_out_q   <= mb_out_d;
    end
  end

  // Core array keeps its contents through reset
  always_ff @(posedge clk) begin
    if (core_we_s) begin
      core[addr_q] <= core_wdata_s;
    end
  end

  assign membus_addr_ack_p0 = addr_ack_q[0];
  assign membus_addr_ack_p1 = addr_ack_q[1];
  assign membus_addr_ack_p2 = addr_ack_q[2];
  assign membus_addr_ack_p3 = addr_ack_q[3];
  assign membus_rd_rs_p0    = rd_rs_q[0];
  assign membus_rd_rs_p1    = rd_rs_q[1];
  assign membus_rd_rs_p2    = rd_rs_q[2];
  assign membus_rd_rs_p3    = rd_rs_q[3];
  assign membus_mb_out_p0   = mb_out_q[0];
  assign membus_mb_out_p1   = mb_out_q[1];
  assign membus_mb_out_p2   = mb_out_q[2];
  assign membus_mb_out_p3   = mb_out_q[3];
endmodule

// File: tb/tb_core161c_memory.sv
// Directed self-checking bench for core161c_memory.
module tb_core161c_memory;
  logic clk = 1'b0;
  logic reset, power, sw_single_step, sw_restart;
  logic [3:0] rd_rq, wr_rq, rq_cyc, fmc, wr_rs, ack, rd_rs;
  logic [3:0][3:0]  sel;
  logic [3:0][14:0] ma;
  logic [3:0][35:0] mb_in, mb_out;
  int total = 0;
  int bad = 0;

  localparam logic [35:0] W300 = 36'o123456111222;
  localparam logic [35:0] W141 = 36'o777740000100;

  always #5 clk = ~clk;

  core161c_memory dut (
    .clk(clk), .reset(reset), .power(power),
    .sw_single_step(sw_single_step), .sw_restart(sw_restart),
    .membus_rd_rq_p0(rd_rq[0]), .membus_wr_rq_p0(wr_rq[0]), .membus_rq_cyc_p0(rq_cyc[0]),
    .membus_sel_p0(sel[0]), .membus_fmc_select_p0(fmc[0]), .membus_ma_p0(ma[0]),
    .membus_wr_rs_p0(wr_rs[0]), .membus_mb_in_p0(mb_in[0]),
    .membus_addr_ack_p0(ack[0]), .membus_rd_rs_p0(rd_rs[0]), .membus_mb_out_p0(mb_out[0]),
    .membus_rd_rq_p1(rd_rq[1]), .membus_wr_rq_p1(wr_rq[1]), .membus_rq_cyc_p1(rq_cyc[1]),
    .membus_sel_p1(sel[1]), .membus_fmc_select_p1(fmc[1]), .membus_ma_p1(ma[1]),
    .membus_wr_rs_p1(wr_rs[1]), .membus_mb_in_p1(mb_in[1]),
    .membus_addr_ack_p1(ack[1]), .membus_rd_rs_p1(rd_rs[1]), .membus_mb_out_p1(mb_out[1]),
    .membus_rd_rq_p2(rd_rq[2]), .membus_wr_rq_p2(wr_rq[2]), .membus_rq_cyc_p2(rq_cyc[2]),
    .membus_sel_p2(sel[2]), .membus_fmc_select_p2(fmc[2]), .membus_ma_p2(ma[2]),
    .membus_wr_rs_p2(wr_rs[2]), .membus_mb_in_p2(mb_in[2]),
    .membus_addr_ack_p2(ack[2]), .membus_rd_rs_p2(rd_rs[2]), .membus_mb_out_p2(mb_out[2]),
    .membus_rd_rq_p3(rd_rq[3]), .membus_wr_rq_p3(wr_rq[3]), .membus_rq_cyc_p3(rq_cyc[3]),
    .membus_sel_p3(sel[3]), .membus_fmc_select_p3(fmc[3]), .membus_ma_p3(ma[3]),
    .membus_wr_rs_p3(wr_rs[3]), .membus_mb_in_p3(mb_in[3]),
    .membus_addr_ack_p3(ack[3]), .membus_rd_rs_p3(rd_rs[3]), .membus_mb_out_p3(mb_out[3])
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    rd_rq = 4'b0000; wr_rq = 4'b0000; rq_cyc = 4'b0000; fmc = 4'b0000; wr_rs = 4'b0000;
    sel = '0; ma = '0; mb_in = '0;
  endtask

  // Steps clocks until addr_ack of port p, at most 12 cycles; n=12 means it never came
  task automatic wait_ack(input int p, output int n);
    n = 0;
    while (ack[p] !== 1'b1 && n < 12) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; power = 1'b1; sw_single_step = 1'b0; sw_restart = 1'b0;
    clear_req();
    #2;
    total++;
    if ({ack, rd_rs} !== 8'h00) begin
      bad++; $display("FAIL reset_strobes got=%b exp=0", {ack, rd_rs});
    end
    total++;
    if (mb_out !== '0) begin
      bad++; $display("FAIL reset_mb_out got=%0h exp=0", mb_out);
    end
    cyc(); cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_read();
    int n;
    dut.core[14'o300] = W300;
    rd_rq[0] = 1'b1; rq_cyc[0] = 1'b1; sel[0] = 4'b0000; ma[0] = 15'o300;
    wait_ack(0, n);
    total++;
    if (n !== 1) begin bad++; $display("FAIL read_ack_latency got=%0d exp=1", n); end
    cyc();
    total++;
    if (ack[0] !== 1'b0 || rd_rs[0] !== 1'b0) begin
      bad++; $display("FAIL read_ack_width got ack=%b rs=%b exp 0 0", ack[0], rd_rs[0]);
    end
    cyc(); cyc();
    total++;
    if (rd_rs[0] !== 1'b1 || mb_out[0] !== W300) begin
      bad++; $display("FAIL read_data got rs=%b mb=%o exp 1 %o", rd_rs[0], mb_out[0], W300);
    end
    cyc();
    total++;
    if (rd_rs[0] !== 1'b0 || mb_out[0] !== 36'd0) begin
      bad++; $display("FAIL read_rs_width got rs=%b mb=%o exp 0 0", rd_rs[0], mb_out[0]);
    end
    clear_req();
    repeat (4) cyc();
    total++;
    if (dut.core[14'o300] !== W300) begin
      bad++; $display("FAIL read_restore got=%o exp=%o", dut.core[14'o300], W300);
    end
  endtask

  task automatic test_write();
    int n;
    bit seen;
    dut.core[14'o141] = 36'o5;
    wr_rq[0] = 1'b1; rq_cyc[0] = 1'b1; ma[0] = 15'o141;
    wait_ack(0, n);
    total++;
    if (n !== 1) begin bad++; $display("FAIL write_ack_latency got=%0d exp=1", n); end
    seen = 1'b0;
    repeat (3) begin
      cyc();
      if (rd_rs[0] !== 1'b0 || mb_out[0] !== 36'd0) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL write_no_rd_rs got=1 exp=0"); end
    mb_in[0] = W141; wr_rs[0] = 1'b1;
    cyc();
    clear_req();
    repeat (4) cyc();
    total++;
    if (dut.core[14'o141] !== W141) begin
      bad++; $display("FAIL write_data got=%o exp=%o", dut.core[14'o141], W141);
    end
  endtask

  task automatic test_rmw();
    int n;
    dut.core[14'o142] = 36'd2;
    rd_rq[0] = 1'b1; wr_rq[0] = 1'b1; rq_cyc[0] = 1'b1; ma[0] = 15'o142;
    wait_ack(0, n);
    cyc(); cyc(); cyc();
    total++;
    if (rd_rs[0] !== 1'b1 || mb_out[0] !== 36'd2) begin
      bad++; $display("FAIL rmw_read got rs=%b mb=%o exp 1 2", rd_rs[0], mb_out[0]);
    end
    mb_in[0] = 36'd3; wr_rs[0] = 1'b1;
    cyc();
    clear_req();
    repeat (4) cyc();
    total++;
    if (dut.core[14'o142] !== 36'd3) begin
      bad++; $display("FAIL rmw_write got=%o exp=3", dut.core[14'o142]);
    end
  endtask

  task automatic test_reject();
    bit any;
    dut.core[14'o5] = 36'o55;
    for (int k = 0; k < 2; k++) begin
      rd_rq[0] = 1'b1; wr_rq[0] = 1'b1; rq_cyc[0] = 1'b1; ma[0] = 15'o5;
      fmc[0] = (k == 0); sel[0] = (k == 0) ? 4'b0000 : 4'b0001;
      mb_in[0] = 36'o7; wr_rs[0] = 1'b1;
      any = 1'b0;
      repeat (8) begin
        cyc();
        if (ack !== 4'b0000 || rd_rs !== 4'b0000 || mb_out !== '0) any = 1'b1;
      end
      total++;
      if (any) begin bad++; $display("FAIL reject_%0d got=responded exp=silent", k); end
      total++;
      if (dut.core[14'o5] !== 36'o55) begin
        bad++; $display("FAIL reject_core_%0d got=%o exp=55", k, dut.core[14'o5]);
      end
      clear_req();
      cyc();
    end
  endtask

  task automatic test_power();
    int n;
    bit any;
    power = 1'b0;
    rd_rq[0] = 1'b1; rq_cyc[0] = 1'b1; ma[0] = 15'o300;
    any = 1'b0;
    repeat (6) begin
      cyc();
      if (ack !== 4'b0000 || mb_out !== '0) any = 1'b1;
    end
    total++;
    if (any) begin bad++; $display("FAIL power_off got=responded exp=silent"); end
    power = 1'b1;
    wait_ack(0, n);
    total++;
    if (n !== 1) begin bad++; $display("FAIL power_on_ack got=%0d exp=1", n); end
    cyc();
    clear_req();
    repeat (8) cyc();
  endtask

  task automatic test_priority();
    int n;
    bit any;
    rd_rq[0] = 1'b1; rq_cyc[0] = 1'b1; ma[0] = 15'o300;
    rd_rq[1] = 1'b1; rq_cyc[1] = 1'b1; ma[1] = 15'o142;
    wait_ack(0, n);
    total++;
    if (n !== 1 || ack[1] !== 1'b0) begin
      bad++; $display("FAIL prio_first got n=%0d ack1=%b exp 1 0", n, ack[1]);
    end
    any = 1'b0;
    repeat (8) begin
      cyc();
      if (ack[1] !== 1'b0) any = 1'b1;
    end
    total++;
    if (any) begin bad++; $display("FAIL prio_hold got=p1_acked exp=no_ack"); end
    rd_rq[0] = 1'b0; rq_cyc[0] = 1'b0;
    wait_ack(1, n);
    total++;
    if (n !== 2) begin bad++; $display("FAIL prio_second got=%0d exp=2", n); end
    cyc(); cyc(); cyc();
    total++;
    if (rd_rs[1] !== 1'b1 || mb_out[1] !== 36'd3 || mb_out[0] !== 36'd0) begin
      bad++; $display("FAIL prio_p1_data got rs=%b mb1=%o mb0=%o exp 1 3 0",
                      rd_rs[1], mb_out[1], mb_out[0]);
    end
    clear_req();
    repeat (4) cyc();
  endtask

  task automatic test_reset_mid();
    int n;
    dut.core[14'o200] = 36'o1234;
    rd_rq[0] = 1'b1; wr_rq[0] = 1'b1; rq_cyc[0] = 1'b1; ma[0] = 15'o200;
    wait_ack(0, n);
    cyc(); cyc(); cyc();
    total++;
    if (rd_rs[0] !== 1'b1 || mb_out[0] !== 36'o1234) begin
      bad++; $display("FAIL abort_pre got rs=%b mb=%o exp 1 1234", rd_rs[0], mb_out[0]);
    end
    reset = 1'b0;
    #1;
    total++;
    if (rd_rs !== 4'b0000 || ack !== 4'b0000 || mb_out !== '0) begin
      bad++; $display("FAIL abort_outputs got rs=%b ack=%b mb0=%o exp 0", rd_rs, ack, mb_out[0]);
    end
    total++;
    if (dut.core[14'o200] !== 36'd0) begin
      bad++; $display("FAIL abort_core got=%o exp=0", dut.core[14'o200]);
    end
    clear_req();
    cyc();
    reset = 1'b1;
    cyc();
    rd_rq[0] = 1'b1; rq_cyc[0] = 1'b1; ma[0] = 15'o300;
    wait_ack(0, n);
    cyc(); cyc(); cyc();
    total++;
    if (n !== 1 || rd_rs[0] !== 1'b1 || mb_out[0] !== W300) begin
      bad++; $display("FAIL abort_recover got n=%0d rs=%b mb=%o exp 1 1 %o", n, rd_rs[0], mb_out[0], W300);
    end
    clear_req();
    repeat (4) cyc();
  endtask

  task automatic test_single_step();
    int n;
    bit any;
    sw_single_step = 1'b1;
    rd_rq[0] = 1'b1; rq_cyc[0] = 1'b1; ma[0] = 15'o141;
    wait_ack(0, n);
    cyc(); cyc(); cyc();
    total++;
    if (rd_rs[0] !== 1'b1 || mb_out[0] !== W141) begin
      bad++; $display("FAIL step_read got rs=%b mb=%o exp 1 %o", rd_rs[0], mb_out[0], W141);
    end
    rd_rq[0] = 1'b0; rq_cyc[0] = 1'b0;
    rd_rq[1] = 1'b1; rq_cyc[1] = 1'b1; ma[1] = 15'o142;
    any = 1'b0;
    repeat (6) begin
      cyc();
      if (ack !== 4'b0000) any = 1'b1;
    end
    total++;
    if (any) begin bad++; $display("FAIL step_hold got=acked exp=held"); end
    sw_restart = 1'b1;
    cyc();
    sw_restart = 1'b0;
    wait_ack(1, n);
    total++;
    if (n !== 2) begin bad++; $display("FAIL step_release got=%0d exp=2", n); end
    sw_single_step = 1'b0;
    clear_req();
    repeat (8) cyc();
    total++;
    if (dut.core[14'o141] !== W141) begin
      bad++; $display("FAIL step_restore got=%o exp=%o", dut.core[14'o141], W141);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_rmw();
    test_reject();
    test_power();
    test_priority();
    test_reset_mid();
    test_single_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core161c_memory.md
Name: core161c_memory

Overview:
- 16K-word × 36-bit core memory module for the PDP-10 membus, with four processor ports (p0–p3).
- Accepts read, write and read-modify-write cycles from the KA10 processor (or other bus masters).
- Responds with address acknowledge and read restart, and receives write data on write restart.
- Sits beside the ka10 CPU in the pdp10 top level.

Parameters:
- memsel_p0, 4'b0000, module-select value for port 0; the module responds when membus_sel_p0 equals it.
- memsel_p1, 4'b0000, same for port 1.
- memsel_p2, 4'b0000, same for port 2.
- memsel_p3, 4'b0000, same for port 3.
- READ_DLY, 3, clocks from addr_ack to rd_rs.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- power  in  1  module power; when 0 the module is idle and all outputs are 0.
- sw_single_step  in  1  when 1, halt in DONE after each cycle until sw_restart.
- sw_restart  in  1  in single-step mode, releases the halted cycle.
- For each N in 0..3, port N has:
  - membus_rd_rq_pN  in  1  read requested.
  - membus_wr_rq_pN  in  1  write requested.
  - membus_rq_cyc_pN  in  1  cycle request.
  - membus_sel_pN  in  4  address bits 18:21.
  - membus_fmc_select_pN  in  1  fast memory selected; the module ignores the request.
  - membus_ma_pN  in  15  address bits 21:35; the word index is bits 22:35.
  - membus_wr_rs_pN  in  1  write restart; mb_in is valid.
  - membus_mb_in_pN  in  36  write data.
  - membus_addr_ack_pN  out  1  address acknowledge pulse.
  - membus_rd_rs_pN  out  1  read restart pulse.
  - membus_mb_out_pN  out  36  read data; 0 when not driving (the bus is wire-ORed).

Behaviour:
- Storage array is named core, [0:16383] of 36 bits.
  - It is not cleared by reset and must be hierarchically loadable by a testbench.
- Reset (async, active low) and power==0:
  - State goes to IDLE.
  - All addr_ack, rd_rs and mb_out outputs are 0; the internal mb register is cleared.
- Request qualifying, in IDLE, evaluated every clock:
  - Port N qualifies when rq_cyc_pN=1, sel_pN==memsel_pN, fmc_select_pN=0 and (rd_rq_pN or wr_rq_pN).
  - Fixed priority: p0 > p1 > p2 > p3.
- On accepting port N:
  - Latch the port number, word index ma_pN[22:35], rd and wr flags.
  - Next clock: pulse addr_ack_pN high for exactly 1 clock; state goes to READ.
- READ:
  - Wait READ_DLY clocks, then mb ← core[addr] and core[addr] ← 0 (destructive read).
  - If rd: pulse rd_rs_pN for exactly 1 clock; mb_out_pN = mb during that clock only, 0 at all other times.
  - Then: if wr, go to WAIT_WR; otherwise go to WRITE (restore).
- WAIT_WR:
  - mb_out is 0.
  - On wr_rs_pN=1: mb ← mb_in_pN, then go to WRITE.
  - If rq_cyc_pN drops first: go to WRITE with mb unchanged. For a write-only cycle mb is 0, so the word becomes 0.
- WRITE: core[addr] ← mb (1 clock), then go to DONE.
- DONE:
  - If sw_single_step=1, hold until a sw_restart high clock.
  - Then wait for rq_cyc of the latched port = 0 before returning to IDLE. One cycle per request; no re-acceptance while the requester holds rq_cyc.
- Pure write (wr only): no rd_rs pulse. The old word is still read and discarded.
- Read-modify-write (rd and wr): rd_rs first, then wait for wr_rs; the new data is written.
- Simultaneous requests: the lower-numbered port wins; the losers wait, unacknowledged, until IDLE.
- Requests from other ports during a busy cycle are ignored until IDLE; no queueing.
- Reset or power loss mid-cycle: abort immediately; the word being cycled keeps whatever core currently holds.

Decomposition:
- Shared package holds:
  - State enum IDLE/READ/WAIT_WR/WRITE/DONE.
  - Word width 36, address width 14, memory depth 16384.
- One natural sub-module: core161c_port_arb, which does port qualification and priority selection for the 4 ports and produces the selected index and a valid flag.

Test Plan:
- Read p0: core['o300]=36'o123456111222; rd_rq, rq_cyc, sel=0, ma='o300 → addr_ack 1 clk, rd_rs 1 clk with mb_out=36'o123456111222; core['o300] afterwards still 36'o123456111222.
- Write p0: wr_rq to 'o141; wr_rs with mb_in=36'o777740000100 → no rd_rs; core['o141]=36'o777740000100.
- Read-modify-write 'o142 (initially 2): rd_rs returns 2; wr_rs with 3 → core['o142]=3.
- Rejection: fmc_select=1 at ma=5, or sel=4'b0001 with memsel_p0=0 → no addr_ack, core unchanged, mb_out stays 0.
- Priority: p0 and p1 request in the same clock → p0 acked first; p1 acked only after p0 drops rq_cyc.
- Reset low during WAIT_WR → all outputs 0 immediately; next request serviced normally. Also: single_step=1 holds in DONE until a sw_restart pulse.
